// File: rtl/alarm_trigger.sv
// Alarm source: counts consecutive wrong codes, raises the alarm level for a
// fixed time, then holds a silent lockout before accepting entries again.
module alarm_trigger #(
    parameter int MAX_FAILS   = 3,
    parameter int ALARM_TICKS = 800000,
    parameter int LOCK_TICKS  = 1600000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       check_valid,
    input  logic       check_ok,
    input  logic       admin_clear,
    output logic       alarm,
    output logic       unlock,
    output logic       lockout,
    output logic [3:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALARM   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam logic [4:0]  MAX_FAILS_C = 5'(MAX_FAILS);
    localparam logic [3:0]  FAIL_SAT_C  = 4'(MAX_FAILS);
    localparam logic [23:0] ALARM_LOAD  = 24'(ALARM_TICKS - 1);
    localparam logic [23:0] LOCK_LOAD   = 24'(LOCK_TICKS - 1);

    state_t      state_r;
    state_t      state_s;
    logic [23:0] timer_r;
    logic [23:0] timer_s;
    logic [3:0]  fail_cnt_r;
    logic [3:0]  fail_cnt_s;
    logic [4:0]  fail_inc_s;
    logic        alarm_r;
    logic        alarm_s;
    logic        unlock_r;
    logic        unlock_s;
    logic        lockout_r;
    logic        lockout_s;

    // State, timer, counter and all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            timer_r    <= 24'd0;
            fail_cnt_r <= 4'd0;
            alarm_r    <= 1'b0;
            unlock_r   <= 1'b0;
            lockout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            fail_cnt_r <= fail_cnt_s;
            alarm_r    <= alarm_s;
            unlock_r   <= unlock_s;
            lockout_r  <= lockout_s;
        end
    end

    assign fail_inc_s = {1'b0, fail_cnt_r} + 5'd1;

    // Next-state, timer and fail-counter logic; admin_clear overrides everything.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        fail_cnt_s = fail_cnt_r;
        if (admin_clear) begin
            state_s    = ST_IDLE;
            timer_s    = 24'd0;
            fail_cnt_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (check_valid && check_ok) begin
                        fail_cnt_s = 4'd0;
                    end else if (check_valid) begin
                        if (fail_inc_s < MAX_FAILS_C) begin
                            fail_cnt_s = fail_inc_s[3:0];
                        end else begin
                            fail_cnt_s = FAIL_SAT_C;
                            state_s    = ST_ALARM;
                            timer_s    = ALARM_LOAD;
                        end
                    end else begin
                        fail_cnt_s = fail_cnt_r;
                    end
                end
                ST_ALARM: begin
                    if (timer_r == 24'd0) begin
                        state_s = ST_LOCKOUT;
                        timer_s = LOCK_LOAD;
                    end else begin
                        timer_s = timer_r - 24'd1;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_r == 24'd0) begin
                        state_s    = ST_IDLE;
                        fail_cnt_s = 4'd0;
                    end else begin
                        timer_s = timer_r - 24'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a quiet, cleared idle.
                    state_s    = ST_IDLE;
                    timer_s    = 24'd0;
                    fail_cnt_s = 4'd0;
                end
            endcase
        end
    end

    // Output values for the next cycle, derived from the upcoming state.
    always_comb begin
        alarm_s   = 1'b0;
        lockout_s = 1'b0;
        unlock_s  = 1'b0;
        case (state_s)
            ST_ALARM: begin
                alarm_s   = 1'b1;
                lockout_s = 1'b1;
            end
            ST_LOCKOUT: begin
                alarm_s   = 1'b0;
                lockout_s = 1'b1;
            end
            default: begin
                alarm_s   = 1'b0;
                lockout_s = 1'b0;
            end
        endcase
        if ((state_r == ST_IDLE) && check_valid && check_ok && !admin_clear) begin
            unlock_s = 1'b1;
        end else begin
            unlock_s = 1'b0;
        end
    end

    assign alarm    = alarm_r;
    assign unlock   = unlock_r;
    assign lockout  = lockout_r;
    assign fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with MAX_FAILS=3, ALARM_TICKS=10, LOCK_TICKS=20.
module tb_alarm_trigger;

    logic       clk;
    logic       rst;
    logic       check_valid;
    logic       check_ok;
    logic       admin_clear;
    logic       alarm;
    logic       unlock;
    logic       lockout;
    logic [3:0] fail_cnt;

    int errors;
    int checks;

    alarm_trigger #(
        .MAX_FAILS  (3),
        .ALARM_TICKS(10),
        .LOCK_TICKS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .check_valid(check_valid),
        .check_ok   (check_ok),
        .admin_clear(admin_clear),
        .alarm      (alarm),
        .unlock     (unlock),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one code result for a single cycle; returns at the negedge where
    // the registered response is visible.
    task automatic pulse_check(input logic ok);
        @(negedge clk);
        check_valid = 1'b1;
        check_ok    = ok;
        @(negedge clk);
        check_valid = 1'b0;
        check_ok    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        check_valid = 1'b0;
        check_ok = 1'b0;
        admin_clear = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({alarm, unlock, lockout, fail_cnt} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%b u=%b l=%b f=%0d, want all 0", alarm, unlock, lockout, fail_cnt);
        end
        rst = 1'b0;
        pulse_check(1'b1);
        checks++;
        if (unlock !== 1'b1 || fail_cnt !== 4'd0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL good_code: got u=%b f=%0d a=%b, want u=1 f=0 a=0", unlock, fail_cnt, alarm);
        end
        @(negedge clk);
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("FAIL unlock_width: got %b, want 0", unlock);
        end
    endtask

    task automatic test_count_then_good;
        pulse_check(1'b0);
        checks++;
        if (fail_cnt !== 4'd1 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL fail_1: got f=%0d u=%b, want f=1 u=0", fail_cnt, unlock);
        end
        pulse_check(1'b0);
        checks++;
        if (fail_cnt !== 4'd2 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL fail_2: got f=%0d a=%b, want f=2 a=0", fail_cnt, alarm);
        end
        pulse_check(1'b1);
        checks++;
        if (fail_cnt !== 4'd0 || unlock !== 1'b1 || alarm !== 1'b0 || lockout !== 1'b0) begin
            errors++;
            $display("FAIL good_after_fails: got f=%0d u=%b a=%b l=%b, want f=0 u=1 a=0 l=0",
                     fail_cnt, unlock, alarm, lockout);
        end
        @(negedge clk);
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("FAIL unlock_width2: got %b, want 0", unlock);
        end
    endtask

    task automatic test_alarm_sequence;
        int   alarm_cycles;
        int   lock_cycles;
        logic unlock_seen;
        alarm_cycles = 0;
        lock_cycles  = 0;
        unlock_seen  = 1'b0;
        pulse_check(1'b0);
        pulse_check(1'b0);
        pulse_check(1'b0);
        checks++;
        if (alarm !== 1'b1 || lockout !== 1'b1 || fail_cnt !== 4'd3) begin
            errors++;
            $display("FAIL alarm_entry: got a=%b l=%b f=%0d, want a=1 l=1 f=3", alarm, lockout, fail_cnt);
        end
        for (int i = 0; i < 60; i++) begin
            if (alarm === 1'b1) alarm_cycles++;
            if (lockout === 1'b1) lock_cycles++;
            if (unlock === 1'b1) unlock_seen = 1'b1;
            if (i == 17) begin
                checks++;
                if (fail_cnt !== 4'd3) begin
                    errors++;
                    $display("FAIL ignored_count: got f=%0d, want 3", fail_cnt);
                end
            end
            check_valid = (i == 15);
            check_ok    = (i == 15);
            @(negedge clk);
        end
        check_valid = 1'b0;
        check_ok    = 1'b0;
        checks++;
        if (alarm_cycles != 10) begin
            errors++;
            $display("FAIL alarm_length: got %0d cycles, want 10", alarm_cycles);
        end
        checks++;
        if (lock_cycles != 30) begin
            errors++;
            $display("FAIL lockout_length: got %0d cycles, want 30", lock_cycles);
        end
        checks++;
        if (unlock_seen !== 1'b0) begin
            errors++;
            $display("FAIL lockout_unlock: got unlock during lockout, want none");
        end
        checks++;
        if (fail_cnt !== 4'd0 || lockout !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: got f=%0d l=%b a=%b, want f=0 l=0 a=0", fail_cnt, lockout, alarm);
        end
    endtask

    task automatic test_admin_clear_alarm;
        pulse_check(1'b0);
        pulse_check(1'b0);
        pulse_check(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_cycle4: got a=%b, want 1", alarm);
        end
        admin_clear = 1'b1;
        @(negedge clk);
        admin_clear = 1'b0;
        checks++;
        if (alarm !== 1'b0 || lockout !== 1'b0 || fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL admin_clear: got a=%b l=%b f=%0d, want a=0 l=0 f=0", alarm, lockout, fail_cnt);
        end
        pulse_check(1'b1);
        checks++;
        if (unlock !== 1'b1) begin
            errors++;
            $display("FAIL unlock_after_clear: got %b, want 1", unlock);
        end
    endtask

    task automatic test_clear_priority;
        pulse_check(1'b0);
        pulse_check(1'b0);
        checks++;
        if (fail_cnt !== 4'd2) begin
            errors++;
            $display("FAIL pre_clear_count: got f=%0d, want 2", fail_cnt);
        end
        @(negedge clk);
        admin_clear = 1'b1;
        check_valid = 1'b1;
        check_ok    = 1'b0;
        @(negedge clk);
        admin_clear = 1'b0;
        check_valid = 1'b0;
        checks++;
        if (fail_cnt !== 4'd0 || alarm !== 1'b0 || lockout !== 1'b0 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: got f=%0d a=%b l=%b u=%b, want f=0 a=0 l=0 u=0",
                     fail_cnt, alarm, lockout, unlock);
        end
        @(negedge clk);
        admin_clear = 1'b1;
        check_valid = 1'b1;
        check_ok    = 1'b1;
        @(negedge clk);
        admin_clear = 1'b0;
        check_valid = 1'b0;
        check_ok    = 1'b0;
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("FAIL clear_drops_good: got u=%b, want 0", unlock);
        end
    endtask

    task automatic test_reset_in_alarm;
        pulse_check(1'b0);
        pulse_check(1'b0);
        pulse_check(1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (alarm !== 1'b0 || lockout !== 1'b0 || fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got a=%b l=%b f=%0d, want a=0 l=0 f=0", alarm, lockout, fail_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_check(1'b1);
        checks++;
        if (unlock !== 1'b1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL unlock_after_reset: got u=%b a=%b, want u=1 a=0", unlock, alarm);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_count_then_good();
        test_alarm_sequence();
        test_admin_clear_alarm();
        test_clear_priority();
        test_reset_in_alarm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
